// File: rtl/nios_mult_pipe_if.sv
// rtl/nios_mult_pipe_if.sv - issue/result handshake bundle for the pipelined multiplier
interface nios_mult_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  // multiplier side
  modport slave (
    input  in_valid, in_src1, in_src2, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );

  // issuing/consuming side
  modport master (
    output in_valid, in_src1, in_src2, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/nios_mult_pipe.sv
// rtl/nios_mult_pipe.sv - three-stage limb multiplier, optional flush via NIOS_MULT_PIPE_FLUSH_EN
module nios_mult_pipe #(
  parameter int DATA_W = 32,
  parameter int LIMB_W = 16,
  parameter int TAG_W  = 5
) (
  input  logic clk,
  input  logic reset,
`ifdef NIOS_MULT_PIPE_FLUSH_EN
  input  logic flush,
`endif
  nios_mult_pipe_if.slave bus
);
  localparam int NLIMB = DATA_W / LIMB_W;
  localparam int NPP   = NLIMB * NLIMB;
  localparam int PW    = 2 * DATA_W;
  localparam int PPW   = 2 * LIMB_W;

  logic              adv;
  logic              kill;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_mode;
  logic [TAG_W-1:0]  s1_tag;

  logic [PPW-1:0]    pp_next [NPP];
  logic              s2_valid;
  logic [PPW-1:0]    s2_pp [NPP];
  logic [DATA_W-1:0] s2_a;
  logic [DATA_W-1:0] s2_b;
  logic              s2_neg_a;
  logic              s2_neg_b;
  logic [1:0]        s2_mode;
  logic [TAG_W-1:0]  s2_tag;

  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] res_next;
  logic              s3_valid;
  logic [DATA_W-1:0] s3_result;
  logic [TAG_W-1:0]  s3_tag;

`ifdef NIOS_MULT_PIPE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // Whole pipe moves together; it stalls only when a finished result is refused.
  assign adv          = ~s3_valid | bus.out_ready;
  assign bus.in_ready = adv & ~kill;

  // S1: capture operands, mode and tag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (kill) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
    end
    if (adv) begin
      s1_a    <= bus.in_src1;
      s1_b    <= bus.in_src2;
      s1_mode <= bus.in_mode;
      s1_tag  <= bus.in_tag;
    end
  end

  // Unsigned limb-by-limb partial products, indexed [i*NLIMB+j] for A limb i, B limb j
  always_comb begin
    pp_next = '{default: '0};
    for (int i = 0; i < NLIMB; i++) begin
      for (int j = 0; j < NLIMB; j++) begin
        pp_next[i*NLIMB+j] = {{LIMB_W{1'b0}}, s1_a[i*LIMB_W +: LIMB_W]} *
                             {{LIMB_W{1'b0}}, s1_b[j*LIMB_W +: LIMB_W]};
      end
    end
  end

  // S2: register partial products and flag which signed corrections apply
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else if (kill) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
    end
    if (adv) begin
      s2_pp    <= pp_next;
      s2_a     <= s1_a;
      s2_b     <= s1_b;
      s2_neg_a <= s1_a[DATA_W-1] & ((s1_mode == 2'b01) | (s1_mode == 2'b10));
      s2_neg_b <= s1_b[DATA_W-1] & (s1_mode == 2'b01);
      s2_mode  <= s1_mode;
      s2_tag   <= s1_tag;
    end
  end

  // Sum the partial products; signed correction only touches the high word
  always_comb begin
    prod = '0;
    for (int k = 0; k < NPP; k++) begin
      prod = prod + (PW'(s2_pp[k]) << (LIMB_W * ((k / NLIMB) + (k % NLIMB))));
    end
    hi = prod[PW-1:DATA_W];
    if (s2_neg_a) hi = hi - s2_b;
    if (s2_neg_b) hi = hi - s2_a;
    res_next = (s2_mode == 2'b00) ? prod[DATA_W-1:0] : hi;
  end

  // S3: output register; a stalled result is held untouched, even across a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid  <= 1'b0;
      s3_result <= '0;
      s3_tag    <= '0;
    end else if (kill) begin
      s3_valid <= s3_valid & ~bus.out_ready;
    end else if (adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_result <= res_next;
        s3_tag    <= s2_tag;
      end
    end
  end

  assign bus.out_valid  = s3_valid;
  assign bus.out_result = s3_result;
  assign bus.out_tag    = s3_tag;
  assign bus.busy       = s1_valid | s2_valid | s3_valid;
endmodule

// File: tb/tb_nios_mult_pipe.sv
// tb/tb_nios_mult_pipe.sv - self-checking bench for nios_mult_pipe
module tb_nios_mult_pipe;
  logic clk = 1'b0;
  logic reset;
`ifdef NIOS_MULT_PIPE_FLUSH_EN
  logic flush;
`endif

  nios_mult_pipe_if #(.DATA_W(32), .TAG_W(5)) bus ();

  nios_mult_pipe #(.DATA_W(32), .LIMB_W(16), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef NIOS_MULT_PIPE_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_result;
  logic [4:0]  held_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: sign/zero extend to 64 bits, multiply, pick the word
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] m);
    logic [63:0] ax, bx, p;
    ax = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    bx = (m == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ax * bx;
    return (m == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: handshakes seen at negedge are those the next posedge commits
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", {63'b0, bus.out_valid}, 64'd1);
        chk("hold_result", {32'b0, bus.out_result}, {32'b0, held_result});
        chk("hold_tag", {59'b0, bus.out_tag}, {59'b0, held_tag});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_result", 64'd1, 64'd0);
        end else begin
          chk("sb_result", {32'b0, bus.out_result}, {32'b0, q[0].result});
          chk("sb_tag", {59'b0, bus.out_tag}, {59'b0, q[0].tag});
          void'(q.pop_front());
          delivered++;
        end
      end
`ifdef NIOS_MULT_PIPE_FLUSH_EN
      if (flush) begin
        if (bus.out_valid && !bus.out_ready) q = q[0:0];
        else q.delete();
      end else
`endif
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{result: model(bus.in_src1, bus.in_src2, bus.in_mode), tag: bus.in_tag});
      end
      stall_prev  = bus.out_valid && !bus.out_ready;
      held_result = bus.out_result;
      held_tag    = bus.out_tag;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input logic [4:0] t);
    bus.in_valid = 1'b1;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  task automatic expect_out(input string name, input logic [31:0] r, input logic [4:0] t);
    chk({name, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
    chk({name, "_result"}, {32'b0, bus.out_result}, {32'b0, r});
    chk({name, "_tag"}, {59'b0, bus.out_tag}, {59'b0, t});
    step();
  endtask

  initial begin
    int n;
    int base;
    logic fired;

    reset         = 1'b1;
`ifdef NIOS_MULT_PIPE_FLUSH_EN
    flush         = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_mode   = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;

    chk("model_pin_uu", {32'b0, model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11)}, 64'hFFFF_FFFE);
    chk("model_pin_su", {32'b0, model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10)}, 64'hFFFF_FFFF);

    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_out_result", {32'b0, bus.out_result}, 64'd0);
    chk("rst_out_tag", {59'b0, bus.out_tag}, 64'd0);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

    // MUL all-ones: latency check
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd1);
    step();
    bus.in_valid = 1'b0;
    chk("lat_c1_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("lat_busy", {63'b0, bus.busy}, 64'd1);
    step();
    chk("lat_c2_valid", {63'b0, bus.out_valid}, 64'd0);
    step();
    expect_out("mul_ones", 32'h0000_0001, 5'd1);

    // High-word modes back to back
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd2); step();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5'd3); step();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd4); step();
    bus.in_valid = 1'b0;
    expect_out("mulxuu", 32'hFFFF_FFFE, 5'd2);
    expect_out("mulxss", 32'h0000_0000, 5'd3);
    expect_out("mulxsu", 32'hFFFF_FFFF, 5'd4);

    // Signed corner cases
    drive(32'h8000_0000, 32'h8000_0000, 2'b01, 5'd5); step();
    drive(32'h8000_0000, 32'h0000_0002, 2'b01, 5'd6); step();
    drive(32'h8000_0000, 32'h0000_0002, 2'b00, 5'd7); step();
    bus.in_valid = 1'b0;
    expect_out("ss_minmin", 32'h4000_0000, 5'd5);
    expect_out("ss_min2", 32'hFFFF_FFFF, 5'd6);
    expect_out("mul_min2", 32'h0000_0000, 5'd7);

    // Stream of 8 with a backpressure window
    base = delivered;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = !(c >= 4 && c <= 7);
      if (n < 8) drive(32'h9E37_79B9 * (n + 1), 32'h8000_0001 ^ (n << 28), 2'(n % 4), 5'(n));
      else bus.in_valid = 1'b0;
      #1;
      if (c >= 4 && c <= 7) chk("stall_in_ready", {63'b0, bus.in_ready}, 64'd0);
      fired = bus.in_valid && bus.in_ready;
      step();
      if (fired) n++;
      if (n == 8 && delivered - base == 8) break;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_accepted", 64'(n), 64'd8);
    chk("stream_delivered", 64'(delivered - base), 64'd8);

    // Reset with three ops in flight
    drive(32'd11, 32'd12, 2'b00, 5'd1); step();
    drive(32'd13, 32'd14, 2'b11, 5'd2); step();
    drive(32'd15, 32'd16, 2'b01, 5'd3); step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst2_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst2_out_result", {32'b0, bus.out_result}, 64'd0);
    drive(32'd7, 32'd6, 2'b00, 5'd9); step();
    bus.in_valid = 1'b0;
    step();
    step();
    expect_out("post_rst", 32'h0000_002A, 5'd9);

`ifdef NIOS_MULT_PIPE_FLUSH_EN
    // Flush with S1/S2 occupied and a stalled S3 result
    bus.out_ready = 1'b0;
    drive(32'd3, 32'd5, 2'b00, 5'd10); step();
    drive(32'd4, 32'd5, 2'b00, 5'd11); step();
    drive(32'd6, 32'd5, 2'b00, 5'd12); step();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'b0, bus.in_ready}, 64'd0);
    step();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    expect_out("flush_keep", 32'd15, 5'd10);
    chk("flush_no_more", {63'b0, bus.out_valid}, 64'd0);
    step();
    chk("flush_busy", {63'b0, bus.busy}, 64'd0);
`endif

    step();
    step();
    chk("end_busy", {63'b0, bus.busy}, 64'd0);
    chk("end_queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
